// File: rtl/pattern_gen_if.sv
// +--------------------------------------------------------------------------+
// | pattern_gen_if : command and bit-serial valid/ready link of pattern_gen  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pattern_gen_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] frames;
  logic [CNT_W-1:0] gap;
  logic             ready;
  logic             valid;
  logic             out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_cnt;

  modport master (
    input  start, frames, gap, ready,
    output valid, out, busy, done, sent_cnt
  );

  modport slave (
    output start, frames, gap, ready,
    input  valid, out, busy, done, sent_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pattern_gen.sv
// +--------------------------------------------------------------------------+
// | pattern_gen : sends a programmed number of fixed-pattern frames, MSB     |
// |               first, over a valid/ready serial link with optional gaps   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module pattern_gen #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b00101,
  parameter int               CNT_W   = 8
) (
  input  wire logic     clk,
  input  wire logic     rst,
  pattern_gen_if.master bus
);

  localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q,       state_d;
  logic [IDX_W-1:0] bit_idx_q,     bit_idx_d;
  logic [CNT_W-1:0] frames_left_q, frames_left_d;
  logic [CNT_W-1:0] gap_len_q,     gap_len_d;
  logic [CNT_W-1:0] gap_cnt_q,     gap_cnt_d;
  logic [CNT_W-1:0] sent_cnt_q,    sent_cnt_d;
  logic             valid_q,       valid_d;
  logic             out_q,         out_d;
  logic             busy_q,        busy_d;
  logic             done_q,        done_d;

  logic [IDX_W-1:0] idx_dec;
  assign idx_dec = bit_idx_q - IDX_ONE;

  // Outputs are computed for the next state so every port comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    frames_left_d = frames_left_q;
    gap_len_d     = gap_len_q;
    gap_cnt_d     = gap_cnt_q;
    sent_cnt_d    = sent_cnt_q;
    valid_d       = valid_q;
    out_d         = out_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        out_d   = 1'b0;
        busy_d  = 1'b0;
        if (bus.start) begin
          sent_cnt_d = CNT_ZERO;
          if (bus.frames != CNT_ZERO) begin
            frames_left_d = bus.frames;
            gap_len_d     = bus.gap;
            bit_idx_d     = LAST_IDX;
            state_d       = S_SEND;
            valid_d       = 1'b1;
            out_d         = PATTERN[LAST_IDX];
            busy_d        = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (bus.ready) begin
          if (bit_idx_q != '0) begin
            bit_idx_d = idx_dec;
            out_d     = PATTERN[idx_dec];
          end else begin
            sent_cnt_d    = sent_cnt_q + CNT_ONE;
            frames_left_d = frames_left_q - CNT_ONE;
            if (frames_left_q == CNT_ONE) begin
              state_d = S_DONE;
              valid_d = 1'b0;
              out_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (gap_len_q == CNT_ZERO) begin
              bit_idx_d = LAST_IDX;
              out_d     = PATTERN[LAST_IDX];
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = gap_len_q;
              valid_d   = 1'b0;
              out_d     = 1'b0;
            end
          end
        end
      end

      S_GAP: begin
        // gap_cnt holds the idle cycles still to show, including this one.
        if (gap_cnt_q == CNT_ONE) begin
          state_d   = S_SEND;
          gap_cnt_d = CNT_ZERO;
          bit_idx_d = LAST_IDX;
          valid_d   = 1'b1;
          out_d     = PATTERN[LAST_IDX];
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        out_d   = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        out_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      bit_idx_q     <= '0;
      frames_left_q <= '0;
      gap_len_q     <= '0;
      gap_cnt_q     <= '0;
      sent_cnt_q    <= '0;
      valid_q       <= 1'b0;
      out_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      frames_left_q <= frames_left_d;
      gap_len_q     <= gap_len_d;
      gap_cnt_q     <= gap_cnt_d;
      sent_cnt_q    <= sent_cnt_d;
      valid_q       <= valid_d;
      out_q         <= out_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.valid    = valid_q;
  assign bus.out      = out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sent_cnt = sent_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_gen.sv
// +--------------------------------------------------------------------------+
// | tb_pattern_gen : directed and randomized bursts against a stream model   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pattern_gen;

  localparam int               PAT_W   = 5;
  localparam logic [PAT_W-1:0] PATTERN = 5'b00101;
  localparam int               CNT_W   = 8;
  localparam int               BUDGET  = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_gen_if #(.CNT_W(CNT_W)) bus ();

  pattern_gen #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the burst is the pattern repeated `frames` times; a gap of `gap`
  // idle cycles follows every frame except the last; done comes right after.
  // ready_mode: 0 = always ready, 1 = random ready, 2 = 4-cycle stall after 2 bits.
  task automatic run_burst(input int frames, input int gap, input int ready_mode,
                           input int restart_at, output logic [63:0] bits);
    bit   exp_q[$];
    int   n        = 0;
    int   gap_left = 0;
    int   stalls   = 0;
    int   total;
    bit   finished = 1'b0;
    bit   ev, ed, rdy;
    bits  = '0;
    total = frames * PAT_W;
    for (int f = 0; f < frames; f++)
      for (int i = PAT_W - 1; i >= 0; i--)
        exp_q.push_back(PATTERN[i]);

    @(negedge clk);
    bus.start  = 1'b1;
    bus.frames = CNT_W'(frames);
    bus.gap    = CNT_W'(gap);
    bus.ready  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.frames = CNT_W'($urandom);
    bus.gap    = CNT_W'($urandom);

    for (int cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      ev = (n < total) && (gap_left == 0);
      ed = (n == total);
      check("valid", 32'(bus.valid), 32'(ev));
      check("out", 32'(bus.out), ev ? 32'(exp_q[0]) : 32'd0);
      check("busy", 32'(bus.busy), 32'(n < total));
      check("done", 32'(bus.done), 32'(ed));
      check("sent_cnt", 32'(bus.sent_cnt), 32'(n / PAT_W));
      if (ed) finished = 1'b1;

      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(n == 2 && stalls < 4);
      endcase
      if (!rdy && ev) stalls++;
      bus.ready  = rdy;
      bus.start  = (cyc == restart_at);
      bus.frames = (cyc == restart_at) ? CNT_W'(9) : bus.frames;

      if (ev && rdy) begin
        bits = {bits[62:0], bus.out};
        void'(exp_q.pop_front());
        n++;
        if ((n % PAT_W) == 0 && n < total) gap_left = gap;
      end else if (!ev && gap_left > 0) begin
        gap_left--;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_seen", 32'(finished), 32'd1);
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_valid", 32'(bus.valid), 32'd0);
    check("final_sent_cnt", 32'(bus.sent_cnt), 32'(frames));
  endtask

  initial begin
    logic [63:0] bits;
    logic [14:0] exp15;
    logic [9:0]  exp10;
    logic [4:0]  exp5;
    bus.start  = 1'b0;
    bus.frames = '0;
    bus.gap    = '0;
    bus.ready  = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sent_cnt", 32'(bus.sent_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Three back-to-back frames
    run_burst(3, 0, 0, -1, bits);
    exp15 = 15'b001010010100101;
    check("stream_3x_nogap", 32'(bits[14:0]), 32'(exp15));

    // Two frames separated by a 3-cycle gap
    run_burst(2, 3, 0, -1, bits);
    exp10 = 10'b0010100101;
    check("stream_2x_gap3", 32'(bits[9:0]), 32'(exp10));

    // Single frame with a stall on bit index 2
    run_burst(1, 0, 2, -1, bits);
    exp5 = 5'b00101;
    check("stream_stall", 32'(bits[4:0]), 32'(exp5));

    // Zero-frame burst
    run_burst(0, 2, 0, -1, bits);

    // Asynchronous reset in the middle of the second frame
    @(negedge clk);
    bus.start  = 1'b1;
    bus.frames = CNT_W'(4);
    bus.gap    = '0;
    bus.ready  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_sent_cnt", 32'(bus.sent_cnt), 32'd1);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.valid), 32'd0);
    check("async_rst_out", 32'(bus.out), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_sent_cnt", 32'(bus.sent_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_burst(1, 0, 0, -1, bits);
    check("stream_after_rst", 32'(bits[4:0]), 32'(exp5));

    // Start pulse during the gap must be ignored
    run_burst(2, 2, 0, 6, bits);
    check("stream_restart_ignored", 32'(bits[9:0]), 32'(exp10));

    // Randomized bursts with random back-pressure
    for (int k = 0; k < 8; k++) begin
      run_burst(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1,
                int'($urandom_range(0, 30)), bits);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Serial pattern transmitter; the source side of the bit-serial valid/in link consumed by the pattern detector.
- On command, emits a programmed number of frames of a fixed bit pattern, one bit per accepted cycle, with an optional idle gap between frames.
- Default pattern is B,B,C,B,C with B=0 and C=1.
- Used as a deterministic stimulus source and as a link-level loopback source. Downstream detected-count must equal the frames sent.

Parameters:
- PAT_W, 5, pattern length in bits (>=2).
- PATTERN, 5'b00101, pattern bits, transmitted MSB first.
- CNT_W, 8, width of the frame count, gap length and sent counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- frames  input  CNT_W  number of frames in the burst; latched on accepted start.
- gap  input  CNT_W  idle cycles between frames; latched on accepted start.
- ready  input  1  downstream accept; a bit transfers on a cycle with valid=1 and ready=1.
- valid  output  1  out carries a pattern bit.
- out  output  1  serial data bit; 0 whenever valid=0.
- busy  output  1  high in SEND and GAP.
- done  output  1  one-cycle pulse at burst end.
- sent_cnt  output  CNT_W  frames fully transferred in the current/last burst.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; valid, out, busy and done=0; sent_cnt=0; bit index, frame and gap counters=0. Takes effect mid-operation immediately; the burst is abandoned and not resumed.
- All outputs are registered.
- IDLE:
  - start=1 with frames!=0: latch frames/gap, clear sent_cnt, bit index=PAT_W-1, go SEND. valid=1 with PATTERN[PAT_W-1] in the cycle after start is sampled.
  - start=1 with frames=0: clear sent_cnt, go DONE, and send no bits.
- SEND: valid=1, out=PATTERN[bit index].
  - ready=0: hold valid and out unchanged (stall), for any number of cycles.
  - ready=1 and bit index>0: decrement bit index.
  - ready=1 and bit index=0 (frame end): sent_cnt+1, remaining frames-1. Then:
    - no frames remain: go DONE.
    - gap=0: reload bit index and stay in SEND; back-to-back frames with no bubble.
    - gap>0: go GAP with gap counter=gap.
- GAP: valid=0, out=0, busy=1; decrement the gap counter each cycle. Leave GAP after exactly gap cycles, reload bit index, and return to SEND. ready is ignored in GAP.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. sent_cnt holds its value until the next accepted start.
- start while busy or in DONE is ignored. Latched frames/gap are unaffected by input changes after acceptance.
- Bit transfers per burst = frames*PAT_W exactly.
- sent_cnt never exceeds frames, so it does not wrap.

Test Plan:
- frames=3, gap=0, ready=1, pulse start: valid high for 15 consecutive cycles starting the cycle after start, out=001010010100101. done pulses 1 cycle after the 15th bit; sent_cnt=3; a detector counts 3.
- frames=2, gap=3, ready=1: valid pattern is 5 high, 3 low (out=0), 5 high. The bits are 00101 then 00101; done follows; sent_cnt=2.
- frames=1, ready held low 4 cycles while out presents bit index 2 (value 1): valid=1 and out=1 held through the stall. The frame completes in 9 cycles and the full frame 00101 is still delivered.
- frames=0, start: valid never asserts; done pulses the cycle after start; sent_cnt=0.
- frames=4, gap=0: drop rst to 0 during the 2nd frame; valid, out, busy and sent_cnt go to 0 without waiting for a clock edge. After release, a new start with frames=1 yields exactly 00101 and sent_cnt=1.
- frames=2, gap=2: pulse start again mid-burst with frames=9; it is ignored. Exactly 10 bits are sent, sent_cnt=2, and only one done pulse occurs.
